// File: rtl/ntt_butterfly_if.sv
// Stream bundle for the NTT butterfly: coefficient beats in, butterfly pairs out.
// A beat transfers on a rising edge where valid and ready are both 1; valid must hold with stable data until then.
interface ntt_butterfly_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [22:0] in_a;
    logic [22:0] in_b;
    logic [22:0] in_w;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] out_x;
    logic [22:0] out_y;
    logic        busy;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_w, out_ready,
        input  in_ready, out_valid, out_x, out_y, busy
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_w, out_ready,
        output in_ready, out_valid, out_x, out_y, busy
    );
endinterface

// File: rtl/ntt_butterfly.sv
// Three-stage radix-2 NTT butterfly mod 8380417 (CT or GS per beat) with elastic stream flow control.
// Mul_Mod is the combinational modular multiplier between S1 and S2.
module ntt_butterfly (
    input  logic           clk,
    input  logic           rst_n,
    ntt_butterfly_if.slave bus
);
    localparam int         W     = 23;
    localparam logic [W:0] Q_EXT = 24'd8380417;

    logic           adv1, adv2, adv3;
    logic           s1_v_q, s1_v_d, s1_mode_q, s1_mode_d;
    logic [W-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_w_q, s1_w_d;
    logic           s2_v_q, s2_v_d, s2_mode_q, s2_mode_d;
    logic [W-1:0]   s2_u_q, s2_u_d, s2_p_q, s2_p_d;
    logic           s3_v_q, s3_v_d;
    logic [W-1:0]   s3_x_q, s3_x_d, s3_y_q, s3_y_d;
    logic [W-1:0]   u_c, v_c, p_c;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_EXT) s = s - Q_EXT;
        return s[W-1:0];
    endfunction

    // Borrow shows up as the extra top bit; adding Q wraps it back into range.
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) d = d + Q_EXT;
        return d[W-1:0];
    endfunction

    assign adv3 = !s3_v_q || bus.out_ready;
    assign adv2 = !s2_v_q || adv3;
    assign adv1 = !s1_v_q || adv2;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s3_v_q;
    assign bus.out_x     = s3_x_q;
    assign bus.out_y     = s3_y_q;
    assign bus.busy      = s1_v_q || s2_v_q || s3_v_q;

    always_comb begin
        u_c = s1_a_q;
        v_c = s1_b_q;
        if (s1_mode_q) begin
            u_c = mod_add(s1_a_q, s1_b_q);
            v_c = mod_sub(s1_a_q, s1_b_q);
        end
    end

    Mul_Mod u_mul (
        .a (v_c),
        .b (s1_w_q),
        .r (p_c)
    );

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_mode_d = s1_mode_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_w_d    = s1_w_q;
        s2_v_d    = s2_v_q;
        s2_mode_d = s2_mode_q;
        s2_u_d    = s2_u_q;
        s2_p_d    = s2_p_q;
        s3_v_d    = s3_v_q;
        s3_x_d    = s3_x_q;
        s3_y_d    = s3_y_q;

        if (adv1) begin
            s1_v_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_mode_d = bus.in_mode;
                s1_a_d    = bus.in_a;
                s1_b_d    = bus.in_b;
                s1_w_d    = bus.in_w;
            end
        end

        if (adv2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_mode_d = s1_mode_q;
                s2_u_d    = u_c;
                s2_p_d    = p_c;
            end
        end

        // GS already did its add/sub before the multiply, so S3 just forwards.
        if (adv3) begin
            s3_v_d = s2_v_q;
            if (s2_v_q) begin
                if (s2_mode_q) begin
                    s3_x_d = s2_u_q;
                    s3_y_d = s2_p_q;
                end else begin
                    s3_x_d = mod_add(s2_u_q, s2_p_q);
                    s3_y_d = mod_sub(s2_u_q, s2_p_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_mode_q <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_w_q    <= '0;
            s2_v_q    <= 1'b0;
            s2_mode_q <= 1'b0;
            s2_u_q    <= '0;
            s2_p_q    <= '0;
            s3_v_q    <= 1'b0;
            s3_x_q    <= '0;
            s3_y_q    <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_mode_q <= s1_mode_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_w_q    <= s1_w_d;
            s2_v_q    <= s2_v_d;
            s2_mode_q <= s2_mode_d;
            s2_u_q    <= s2_u_d;
            s2_p_q    <= s2_p_d;
            s3_v_q    <= s3_v_d;
            s3_x_q    <= s3_x_d;
            s3_y_q    <= s3_y_d;
        end
    end
endmodule

module Mul_Mod (
    input  logic [22:0] a,
    input  logic [22:0] b,
    output logic [22:0] r
);
    localparam logic [45:0] Q_WIDE = 46'd8380417;

    logic [45:0] prod;

    assign prod = {23'd0, a} * {23'd0, b};
    assign r    = 23'(prod % Q_WIDE);
endmodule
